mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified 16-bit memory between the fetch stage (read-only) and the
//  MEM stage (read/write) of the 5-stage pipeline. Sequences each access over MEM_LAT cycles,
//  arbitrates simultaneous requests and drives per-requester stall lines to the hazard logic
//  (if_stall gates pcWrite/IFID_write; dm_stall freezes the EX/MEM and MEM/WB registers).
// PARAMETERS
//  ADDR_W      10  address width (matches the PC/data address width)
//  DATA_W      16  data width
//  MEM_LAT     2   memory cycles per access (>=1); mem_rdata valid on the last BUSY cycle
//  STARVE_MAX  4   consecutive data grants allowed while if_req is pending (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  if_req     in   1       fetch request; held high until if_ack
//  if_addr    in   ADDR_W  fetch address; stable while if_req is high
//  if_ack     out  1       one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction, registered, held until next fetch completes
//  dm_req     in   1       data request; held high until dm_ack
//  dm_we      in   1       1 = write, 0 = read; stable with dm_req
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  write data
//  dm_ack     out  1       one-cycle pulse: data access complete
//  dm_rdata   out  DATA_W  read data, registered; unchanged by writes
//  mem_en     out  1       memory enable, high on every BUSY cycle
//  mem_we     out  1       memory write enable (data writes only)
//  mem_addr   out  ADDR_W  memory address, registered at grant
//  mem_wdata  out  DATA_W  memory write data, registered at grant
//  mem_rdata  in   DATA_W  memory read data
//  if_stall   out  1       if_req & ~if_ack (combinational)
//  dm_stall   out  1       dm_req & ~dm_ack (combinational)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; mem_en, mem_we, if_ack, dm_ack = 0; mem_addr, mem_wdata, if_rdata,
//    dm_rdata, lat_cnt and starve_cnt = 0. Reset during BUSY or RESP aborts the access and
//    produces no ack; a write already presented may or may not reach the memory.
//  - FSM IDLE -> BUSY -> RESP -> IDLE. Grants are made only in IDLE.
//  - IDLE: if any req is sampled high at edge k, grant, latch owner/addr/wdata/we and enter BUSY.
//    Priority: dm over if, except when starve_cnt == STARVE_MAX and if_req is high -> grant fetch.
//  - BUSY: cycles k+1 .. k+MEM_LAT; mem_en = 1 with addr/we/wdata stable; lat_cnt counts
//    1..MEM_LAT. At edge k+MEM_LAT, capture mem_rdata into the owner's rdata (reads only)
//    and enter RESP.
//  - RESP: cycle k+MEM_LAT+1; owner's ack = 1; mem_en = 0; the owner's req is ignored.
//    Always returns to IDLE. Latency from req to ack = MEM_LAT+1 cycles; back-to-back
//    throughput = one access per MEM_LAT+2 cycles.
//  - starve_cnt: +1 on a dm grant while if_req is high, saturating at STARVE_MAX;
//    cleared on a fetch grant or when if_req is low in IDLE.
//  - A req deasserted before its ack is a protocol violation: the access still completes,
//    the ack is still pulsed and the arbiter does not hang.
//  - if_ack and dm_ack are never high in the same cycle. mem_we is never high for a fetch.
// STRUCTURE
//  - Package mem_arb_pkg: state encodings (IDLE, BUSY, RESP) and owner encodings (OWN_IF, OWN_DM).
//  - One sub-module, mem_arb_lat_ctr: load/clear latency counter with a done flag at MEM_LAT.
//  - Everything else (FSM, grant logic, starvation counter, output registers) stays in this module.
// TESTING
//  1. MEM_LAT=2: if_req, if_addr=0x005 at cycle 0, mem returns 0xA1B2 -> mem_en high in
//     cycles 1-2, if_ack in cycle 3, if_rdata=0xA1B2, if_stall high in cycles 0-2.
//  2. if_req and dm_req (read 0x010) rise together -> dm served first (dm_ack at cycle 3),
//     fetch granted at the IDLE in cycle 4, if_ack at cycle 7.
//  3. dm write 0x3FF <- 0xBEEF -> mem_we=1 with mem_wdata=0xBEEF in cycles 1-2, dm_ack in
//     cycle 3, dm_rdata unchanged.
//  4. STARVE_MAX=4: dm_req held high with if_req -> exactly 4 dm acks, then an if_ack,
//     then dm service resumes.
//  5. rst pulsed in cycle 2 of a read -> next cycle IDLE, no ack, mem_en=0; a new
//     if_req is then served normally.
//  6. Random req/we/addr against a memory model for 10k cycles -> every ack matches the
//     model, no double ack, no grant outside IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and sizing helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_lat_ctr.sv
// Access latency counter: load starts at 1, counts up to MEM_LAT, done flags the last BUSY cycle.
module mem_arb_lat_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clear_i,
  output logic done_o
);

  localparam int unsigned CNT_W = cnt_width(MEM_LAT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CNT_W'(MEM_LAT));

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '0 && !done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-memory requests onto one single-port memory, one access at a time,
// with dm priority bounded by a starvation counter protecting the fetch stage.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              busy
);

  localparam int unsigned STARVE_W = cnt_width(STARVE_MAX);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic grant, grant_if, starve_full, lat_done;

  assign starve_full = (starve_q == STARVE_W'(STARVE_MAX));
  assign grant_if    = if_req && (!dm_req || starve_full);
  assign grant       = (state_q == IDLE) && (if_req || dm_req);

  mem_arb_lat_ctr #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_ctr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (grant),
    .clear_i ((state_q == BUSY) && lat_done),
    .done_o  (lat_done)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    starve_d   = starve_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BUSY;
          owner_d = grant_if ? OWN_IF : OWN_DM;
          we_d    = !grant_if && dm_we;
          addr_d  = grant_if ? if_addr : dm_addr;
          wdata_d = grant_if ? '0 : dm_wdata;
        end
        // Starvation only accrues while a fetch is actually waiting behind a data grant.
        if (!if_req || grant_if) begin
          starve_d = '0;
        end else if (!starve_full) begin
          starve_d = starve_q + STARVE_W'(1);
        end
      end
      BUSY: begin
        if (lat_done) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
            else                   dm_rdata_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      starve_q   <= starve_d;
    end
  end

  assign mem_en    = (state_q == BUSY);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_ack    = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req && !if_ack;
  assign dm_stall  = dm_req && !dm_ack;
  assign busy      = (state_q != IDLE);

endmodule
